nzcv_flag_controller: RTL and testbench

- Owns the architectural NZCV condition-flag register of the LEGv8 datapath.
- Builds flags from the ALU result when a flag-setting instruction (ADDS/SUBS/ANDS) completes.
- Tracks in-flight flag-setting operations and stalls issue when its capacity is reached.
- Resolves B.cond / CBZ / CBNZ requests through a valid/ready handshake to fetch. A B.cond waits until every older flag-setting op has written back.

---
 rtl/legv8_cond_pkg.sv | 31 +++
 rtl/nzcv_cond_eval.sv | 38 +++
 rtl/nzcv_flag_controller.sv | 136 +++++++++++++
 tb/tb_nzcv_flag_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_cond_pkg.sv
// Shared LEGv8 condition codes, NZCV bit positions and branch-resolver state encoding.
package legv8_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

endpackage

// File: rtl/nzcv_cond_eval.sv
// Combinational LEGv8 condition evaluation: (NZCV, cond) -> taken.
module nzcv_cond_eval
    import legv8_cond_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_HS: taken = c;
            COND_LO: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/nzcv_flag_controller.sv
// Architectural NZCV register, in-flight flag-op tracking and branch resolution for LEGv8.
module nzcv_flag_controller
    import legv8_cond_pkg::*;
#(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned MAX_INFLIGHT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic             issue_setflags,
    input  logic             alu_done,
    input  logic             alu_setflags,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c_out,
    input  logic             alu_overflow,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [3:0]       br_cond,
    input  logic             br_cbz,
    input  logic             br_cbnz,
    input  logic [WIDTH-1:0] br_operand,
    output logic             br_resp_valid,
    output logic             br_taken,
    output logic [3:0]       flags,
    output logic             stall,
    output logic             err_underflow
);

    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] snapshot;
    logic          completion;
    logic          inc;
    logic          dec;
    logic          is_bcond;
    logic          req_cbz;
    logic          req_cbnz;
    logic          req_op_zero;
    logic [3:0]    req_cond;
    logic          cond_taken;

    assign completion = alu_done & alu_setflags;
    assign stall      = (count == MAX_CNT);
    assign inc        = issue_valid & issue_setflags & ~stall;
    assign dec        = completion & (count != '0);
    assign is_bcond   = ~br_cbz & ~br_cbnz;
    assign br_ready   = (state == ST_IDLE);

    always_comb begin
        count_next = count;
        if (inc && !dec) begin
            count_next = count + ONE;
        end else if (dec && !inc) begin
            count_next = count - ONE;
        end
    end

    // Only the zero-ness of the CBZ/CBNZ operand matters, so that is all that is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            count         <= '0;
            snapshot      <= '0;
            flags         <= '0;
            err_underflow <= 1'b0;
            br_resp_valid <= 1'b0;
            req_cbz       <= 1'b0;
            req_cbnz      <= 1'b0;
            req_op_zero   <= 1'b0;
            req_cond      <= '0;
        end else begin
            count         <= count_next;
            br_resp_valid <= 1'b0;
            if (completion) begin
                flags <= {alu_result[WIDTH-1], (alu_result == '0), alu_c_out, alu_overflow};
                if (count == '0) begin
                    err_underflow <= 1'b1;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (br_valid) begin
                        req_cbz     <= br_cbz;
                        req_cbnz    <= br_cbnz;
                        req_op_zero <= (br_operand == '0);
                        req_cond    <= br_cond;
                        if (is_bcond && (count_next != '0)) begin
                            snapshot <= count_next;
                            state    <= ST_WAIT;
                        end else begin
                            state         <= ST_EVAL;
                            br_resp_valid <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (completion) begin
                        snapshot <= snapshot - ONE;
                        if (snapshot == ONE) begin
                            state         <= ST_EVAL;
                            br_resp_valid <= 1'b1;
                        end
                    end
                end
                ST_EVAL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    nzcv_cond_eval u_cond_eval (
        .flags (flags),
        .cond  (req_cond),
        .taken (cond_taken)
    );

    always_comb begin
        br_taken = 1'b0;
        if (br_resp_valid) begin
            if (req_cbz) begin
                br_taken = req_op_zero;
            end else if (req_cbnz) begin
                br_taken = ~req_op_zero;
            end else begin
                br_taken = cond_taken;
            end
        end
    end

endmodule

// File: tb/tb_nzcv_flag_controller.sv
// Directed bench for nzcv_flag_controller with a behavioural scoreboard checked every cycle.
module tb_nzcv_flag_controller;

    localparam int W    = 64;
    localparam int MAXI = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid, issue_setflags;
    logic          alu_done, alu_setflags;
    logic [W-1:0]  alu_result;
    logic          alu_c_out, alu_overflow;
    logic          br_valid, br_ready;
    logic [3:0]    br_cond;
    logic          br_cbz, br_cbnz;
    logic [W-1:0]  br_operand;
    logic          br_resp_valid, br_taken;
    logic [3:0]    flags;
    logic          stall, err_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nzcv_flag_controller #(.WIDTH(W), .MAX_INFLIGHT(MAXI)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_setflags (issue_setflags),
        .alu_done       (alu_done),
        .alu_setflags   (alu_setflags),
        .alu_result     (alu_result),
        .alu_c_out      (alu_c_out),
        .alu_overflow   (alu_overflow),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_cond        (br_cond),
        .br_cbz         (br_cbz),
        .br_cbnz        (br_cbnz),
        .br_operand     (br_operand),
        .br_resp_valid  (br_resp_valid),
        .br_taken       (br_taken),
        .flags          (flags),
        .stall          (stall),
        .err_underflow  (err_underflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: flags, outstanding op count, and a branch that is idle (0),
    // waiting for m_older older ops (1) or responding this cycle (2).
    bit [3:0]     m_flags;
    int           m_count;
    bit           m_err;
    int           m_phase;
    int           m_older;
    bit           m_cbz, m_cbnz;
    logic [W-1:0] m_op;
    bit [3:0]     m_cond;
    bit           m_comp, m_inc, m_dec;
    int           m_nc;

    function automatic bit cond_holds(input bit [3:0] f, input bit [3:0] c);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags = 4'b0; m_count = 0; m_err = 0; m_phase = 0; m_older = 0;
            m_cbz = 0; m_cbnz = 0; m_op = '0; m_cond = 4'b0;
        end else begin
            m_comp = alu_done && alu_setflags;
            m_inc  = issue_valid && issue_setflags && (m_count < MAXI);
            m_dec  = m_comp && (m_count > 0);
            if (m_comp && m_count == 0) m_err = 1;
            m_nc = m_count + int'(m_inc) - int'(m_dec);
            case (m_phase)
                0: if (br_valid) begin
                    m_cbz = br_cbz; m_cbnz = br_cbnz; m_op = br_operand; m_cond = br_cond;
                    if (br_cbz || br_cbnz) m_phase = 2;
                    else if (m_nc > 0) begin m_phase = 1; m_older = m_nc; end
                    else m_phase = 2;
                end
                1: if (m_comp) begin
                    m_older--;
                    if (m_older == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
            if (m_comp) m_flags = {alu_result[W-1], alu_result == '0, alu_c_out, alu_overflow};
            m_count = m_nc;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("flags", flags, m_flags);
            check("stall", stall, m_count == MAXI);
            check("br_ready", br_ready, m_phase == 0);
            check("br_resp_valid", br_resp_valid, m_phase == 2);
            check("br_taken", br_taken,
                  (m_phase == 2) && (m_cbz ? (m_op == 0) : m_cbnz ? (m_op != 0) : cond_holds(m_flags, m_cond)));
            check("err_underflow", err_underflow, m_err);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic complete(input logic [W-1:0] res, input logic c, input logic v);
        alu_done = 1; alu_setflags = 1; alu_result = res; alu_c_out = c; alu_overflow = v;
        cyc(1);
        alu_done = 0; alu_setflags = 0; alu_c_out = 0; alu_overflow = 0;
    endtask

    task automatic issue(input int n);
        issue_valid = 1; issue_setflags = 1;
        cyc(n);
        issue_valid = 0; issue_setflags = 0;
    endtask

    task automatic branch(input logic [3:0] c, input logic z, input logic nz, input logic [W-1:0] op);
        br_valid = 1; br_cond = c; br_cbz = z; br_cbnz = nz; br_operand = op;
        cyc(1);
        br_valid = 0; br_cbz = 0; br_cbnz = 0;
    endtask

    logic [W-1:0] pat_res [4];
    logic         pat_c   [4];
    logic         pat_v   [4];

    initial begin
        rst_n = 1; issue_valid = 0; issue_setflags = 0; alu_done = 0; alu_setflags = 0;
        alu_result = '0; alu_c_out = 0; alu_overflow = 0; br_valid = 0; br_cond = 0;
        br_cbz = 0; br_cbnz = 0; br_operand = '0;
        #3 rst_n = 0;
        #1;
        check("rst_flags", flags, 4'b0000);
        check("rst_stall", stall, 1'b0);
        check("rst_ready", br_ready, 1'b1);
        check("rst_resp", br_resp_valid, 1'b0);
        check("rst_err", err_underflow, 1'b0);
        cyc(2);
        rst_n = 1;
        cyc(1);

        // ADDS -> 0 with carry, then B.EQ resolves taken one cycle after accept
        issue(1);
        complete('0, 1, 0);
        check("t1_flags", flags, 4'b0110);
        branch(4'b0000, 0, 0, '0);
        check("t1_resp", br_resp_valid, 1'b1);
        check("t1_taken", br_taken, 1'b1);
        cyc(1);
        check("t1_resp_pulse", br_resp_valid, 1'b0);

        // B.GT behind two outstanding SUBS
        issue(2);
        branch(4'b1100, 0, 0, '0);
        check("t2_ready_low", br_ready, 1'b0);
        cyc(2);
        complete(64'd5, 1, 0);
        check("t2_no_early_resp", br_resp_valid, 1'b0);
        complete(64'h8000_0000_0000_0000, 0, 0);
        check("t2_resp", br_resp_valid, 1'b1);
        check("t2_taken", br_taken, 1'b0);
        check("t2_flags", flags, 4'b1000);
        cyc(1);

        // Capacity: three issues stall, a fourth is dropped
        issue(3);
        check("t3_stall", stall, 1'b1);
        issue(1);
        check("t3_stall_hold", stall, 1'b1);
        complete(64'd1, 0, 0);
        check("t3_unstall", stall, 1'b0);
        issue_valid = 1; issue_setflags = 1;
        complete(64'd2, 0, 0);
        issue_valid = 0; issue_setflags = 0;
        check("t3_inc_dec", stall, 1'b0);
        issue(1);
        check("t3_restall", stall, 1'b1);
        complete(64'd3, 1, 0);
        complete(64'd4, 1, 0);
        complete(64'd0, 0, 0);
        check("t3_drained", stall, 1'b0);

        // Younger issue during WAIT is not waited on; younger completion in EVAL is ignored
        issue(1);
        branch(4'b0000, 0, 0, '0);
        issue(1);
        check("t4_waiting", br_resp_valid, 1'b0);
        complete('0, 0, 0);
        check("t4_resp", br_resp_valid, 1'b1);
        check("t4_taken", br_taken, 1'b1);
        complete(64'd7, 0, 0);
        check("t4_flags_after", flags, 4'b0000);

        // CBZ/CBNZ never wait
        issue(2);
        branch(4'b0000, 0, 1, 64'd5);
        check("t5_cbnz_resp", br_resp_valid, 1'b1);
        check("t5_cbnz_taken", br_taken, 1'b1);
        cyc(1);
        branch(4'b0000, 1, 0, 64'd0);
        check("t5_cbz_taken", br_taken, 1'b1);
        cyc(1);
        branch(4'b0000, 1, 1, 64'd3);
        check("t5_both_cbz_wins", br_taken, 1'b0);
        cyc(1);
        complete(64'd9, 0, 0);
        complete(64'd9, 0, 0);

        // Every condition code against four flag patterns
        pat_res[0] = '0;                     pat_c[0] = 1; pat_v[0] = 0;
        pat_res[1] = 64'hFFFF_FFFF_FFFF_FFF0; pat_c[1] = 0; pat_v[1] = 1;
        pat_res[2] = 64'd1;                  pat_c[2] = 1; pat_v[2] = 1;
        pat_res[3] = 64'h8000_0000_0000_0001; pat_c[3] = 1; pat_v[3] = 0;
        for (int p = 0; p < 4; p++) begin
            issue(1);
            complete(pat_res[p], pat_c[p], pat_v[p]);
            for (int c = 0; c < 16; c++) begin
                branch(4'(c), 0, 0, '0);
                cyc(1);
            end
        end
        check("sweep_flags_last", flags, 4'b1010);

        // Reset during WAIT discards the branch; then an unmatched completion flags underflow
        issue(1);
        branch(4'b0100, 0, 0, '0);
        cyc(1);
        #1 rst_n = 0;
        #1;
        check("t6_rst_flags", flags, 4'b0000);
        check("t6_rst_stall", stall, 1'b0);
        check("t6_rst_ready", br_ready, 1'b1);
        check("t6_rst_resp", br_resp_valid, 1'b0);
        cyc(2);
        rst_n = 1;
        cyc(3);
        check("t6_ready_after", br_ready, 1'b1);
        check("t6_no_resp", br_resp_valid, 1'b0);
        complete('1, 0, 0);
        check("t6_err", err_underflow, 1'b1);
        check("t6_flags", flags, 4'b1000);
        check("t6_stall", stall, 1'b0);
        cyc(2);
        check("t6_err_sticky", err_underflow, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
